// File: rtl/cipher_sched_pkg.sv
// Shared types for the two-requester cipher scheduler.
package cipher_sched_pkg;
  localparam int BLOCK_W = 128;
  localparam int KEY_W   = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic req_idx_t;
endpackage

// File: rtl/cipher_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last time wins.
module rr_arb2
  import cipher_sched_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last_grant,
  output logic       gnt_valid,
  output req_idx_t   gnt_idx
);
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = req[1];
    if (&req) gnt_idx = ~last_grant;
  end
endmodule

// File: rtl/cipher_sched.sv
// Shares one cipher core between two requesters: grants, holds core inputs for
// LATENCY cycles, captures the cipher and pulses the winner's end.
module cipher_sched
  import cipher_sched_pkg::*;
#(
  parameter int LATENCY = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_start,
  input  logic [0:BLOCK_W-1] req0_plain,
  input  logic [0:KEY_W-1]   req0_key,
  output logic               req0_end,
  output logic [0:BLOCK_W-1] req0_result,
  input  logic               req1_start,
  input  logic [0:BLOCK_W-1] req1_plain,
  input  logic [0:KEY_W-1]   req1_key,
  output logic               req1_end,
  output logic [0:BLOCK_W-1] req1_result,
  output logic [0:BLOCK_W-1] core_plain,
  output logic [0:KEY_W-1]   core_key,
  input  logic [0:BLOCK_W-1] core_cipher,
  output logic               busy
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  req_idx_t           cur_q, cur_d;
  req_idx_t           last_q, last_d;
  logic [0:BLOCK_W-1] plain_q, plain_d;
  logic [0:KEY_W-1]   key_q, key_d;
  logic [0:BLOCK_W-1] res0_q, res0_d, res1_q, res1_d;
  logic               end0_q, end0_d, end1_q, end1_d;

  logic     gnt_valid;
  req_idx_t gnt_idx;

  rr_arb2 u_arb (
    .req        ({req1_start, req0_start}),
    .last_grant (last_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    last_d  = last_q;
    plain_d = plain_q;
    key_d   = key_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    end0_d  = 1'b0;
    end1_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          cur_d   = gnt_idx;
          last_d  = gnt_idx;
          plain_d = gnt_idx ? req1_plain : req0_plain;
          key_d   = gnt_idx ? req1_key : req0_key;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Capture on the same edge that enters DONE so end and result appear together.
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (cur_q) begin
            res1_d = core_cipher;
            end1_d = 1'b1;
          end else begin
            res0_d = core_cipher;
            end0_d = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= 1'b0;
      last_q  <= 1'b1;
      plain_q <= '0;
      key_q   <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      end0_q  <= 1'b0;
      end1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      plain_q <= plain_d;
      key_q   <= key_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      end0_q  <= end0_d;
      end1_q  <= end1_d;
    end
  end

  assign core_plain  = plain_q;
  assign core_key    = key_q;
  assign req0_result = res0_q;
  assign req1_result = res1_q;
  assign req0_end    = end0_q;
  assign req1_end    = end1_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_cipher_sched.sv
// Bench for cipher_sched: directed scenarios plus random traffic against a
// cycle-arithmetic transaction model and a latency-sensitive core model.
module tb_cipher_sched;
  localparam int L = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s [2];
  logic [127:0]   pl [2];
  logic [63:0]    ky [2];
  logic           req0_end, req1_end, busy;
  logic [0:127]   req0_result, req1_result, core_plain, core_cipher;
  logic [0:63]    core_key;

  always #5 clk = ~clk;

  cipher_sched #(.LATENCY(L), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_start  (s[0]),
    .req0_plain  (pl[0]),
    .req0_key    (ky[0]),
    .req0_end    (req0_end),
    .req0_result (req0_result),
    .req1_start  (s[1]),
    .req1_plain  (pl[1]),
    .req1_key    (ky[1]),
    .req1_end    (req1_end),
    .req1_result (req1_result),
    .core_plain  (core_plain),
    .core_key    (core_key),
    .core_cipher (core_cipher),
    .busy        (busy)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] f(input logic [127:0] p, input logic [63:0] k);
    return ~p ^ {k, k};
  endfunction

  // Transaction model: a grant at edge g ends at edge g+L; next grant no earlier than g+L+2.
  int           cyc = 0, g_cyc = 0, ready = 0, owner = 0;
  bit           inflight, last_g;
  logic [127:0] pend, m_cp;
  logic [63:0]  m_ck;
  logic [127:0] m_res [2];

  task automatic model_reset();
    inflight = 0; ready = 0; last_g = 1;
    m_res[0] = '0; m_res[1] = '0; m_cp = '0; m_ck = '0;
  endtask

  task automatic model_edge();
    int w;
    if (!rst_n) begin model_reset(); return; end
    if (inflight && cyc == g_cyc + L) m_res[owner] = pend;
    if (inflight && cyc == g_cyc + L + 1) inflight = 0;
    if (cyc >= ready && (s[0] || s[1])) begin
      w = (s[0] && s[1]) ? int'(!last_g) : int'(s[1]);
      last_g = bit'(w); owner = w; g_cyc = cyc; ready = cyc + L + 2; inflight = 1;
      m_cp = pl[w]; m_ck = ky[w]; pend = f(pl[w], ky[w]);
    end
  endtask

  function automatic bit exp_end(input int i);
    return inflight && cyc == g_cyc + L && owner == i;
  endfunction

  // Core model: only produces the real cipher once its inputs have been held long enough.
  logic [127:0] prev_p = '0;
  logic [63:0]  prev_k = '0;
  int           stable = 0;

  task automatic core_update();
    logic [127:0] cp;
    logic [63:0]  ck;
    cp = core_plain; ck = core_key;
    if (cp !== prev_p || ck !== prev_k) begin
      stable = 0; prev_p = cp; prev_k = ck;
    end else stable++;
    core_cipher = (stable >= L - 1) ? f(cp, ck) : {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  int end_cnt [2];
  int end_cyc [2];
  int order [$];
  bit outst [2];
  bit contend = 0;

  task automatic clear_obs();
    end_cnt[0] = 0; end_cnt[1] = 0; order.delete();
  endtask

  task automatic check_all();
    chk("end0", 128'(req0_end), 128'(exp_end(0)));
    chk("end1", 128'(req1_end), 128'(exp_end(1)));
    chk("busy", 128'(busy), 128'(inflight && cyc <= g_cyc + L));
    chk("res0", req0_result, m_res[0]);
    chk("res1", req1_result, m_res[1]);
    chk("core_plain", core_plain, m_cp);
    chk("core_key", 128'(core_key), 128'(m_ck));
  endtask

  task automatic raise(input int i, input logic [127:0] p, input logic [63:0] k);
    s[i] = 1'b1; pl[i] = p; ky[i] = k; outst[i] = 1;
  endtask

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    model_edge();
    core_update();
    @(negedge clk);
    check_all();
    for (int i = 0; i < 2; i++)
      if ((i == 0 ? req0_end : req1_end) === 1'b1) begin
        end_cnt[i]++; end_cyc[i] = cyc; order.push_back(i);
      end
  endtask

  // Requesters drop start when their end is visible; in contention mode they re-raise next cycle.
  task automatic run(input int n);
    repeat (n) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (exp_end(i)) begin s[i] = 1'b0; outst[i] = 0; end
        else if (contend && !outst[i]) raise(i, r128(), {$urandom(), $urandom()});
    end
  endtask

  task automatic run_until_ends(input int n, input int budget);
    int b;
    b = 0;
    while (order.size() < n && b < budget) begin run(1); b++; end
    if (order.size() < n) chk("timeout_ends", 128'(order.size()), 128'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s[0] = 1'b0; s[1] = 1'b0; outst[0] = 0; outst[1] = 0;
    model_reset();
    #1;
    check_all();
    chk("rst_end0", 128'(req0_end), 128'(0));
    chk("rst_res0", req0_result, 128'(0));
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  logic [127:0] p6;
  logic [63:0]  k6;
  int           gc;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin s[i] = 0; pl[i] = '0; ky[i] = '0; outst[i] = 0; end
    core_cipher = '0;
    model_reset();
    #1;
    check_all();
    repeat (2) tick();
    rst_n = 1'b1;
    run(1);

    // Single request: all-ones plain, zero key -> cipher is zero.
    clear_obs();
    raise(0, '1, '0);
    run(1);
    gc = g_cyc;
    run(2 * L);
    chk("t1_end_cnt", 128'(end_cnt[0]), 128'(1));
    chk("t1_end_lat", 128'(end_cyc[0] - gc), 128'(L));
    chk("t1_res0", req0_result, 128'(0));
    chk("t1_res1", req1_result, 128'(0));

    // Simultaneous starts after reset: requester 0 first, ends L+2 apart.
    do_reset();
    clear_obs();
    raise(0, r128(), {$urandom(), $urandom()});
    raise(1, r128(), {$urandom(), $urandom()});
    run_until_ends(2, 4 * L);
    if (order.size() >= 2) begin
      chk("t2_first", 128'(order[0]), 128'(0));
      chk("t2_second", 128'(order[1]), 128'(1));
      chk("t2_gap", 128'(end_cyc[1] - end_cyc[0]), 128'(L + 2));
    end
    run(4);

    // Continuous contention: strict alternation.
    clear_obs();
    contend = 1;
    raise(0, r128(), {$urandom(), $urandom()});
    raise(1, r128(), {$urandom(), $urandom()});
    run_until_ends(6, 8 * (L + 2));
    contend = 0;
    for (int i = 0; i < 6 && i < order.size(); i++) chk("t3_order", 128'(order[i]), 128'(i % 2));
    run(3 * (L + 2));

    // Late arrival of requester 1 during requester 0's run.
    clear_obs();
    raise(0, r128(), {$urandom(), $urandom()});
    run(4);
    raise(1, r128(), {$urandom(), $urandom()});
    run_until_ends(2, 4 * L);
    if (order.size() >= 2) begin
      chk("t4_first", 128'(order[0]), 128'(0));
      chk("t4_gap", 128'(end_cyc[1] - end_cyc[0]), 128'(L + 2));
    end
    run(4);

    // Reset mid-run at cnt=4, then a tie must go to requester 0.
    clear_obs();
    raise(0, r128(), {$urandom(), $urandom()});
    run(1);
    run(4);
    chk("t5_busy_before", 128'(busy), 128'(1));
    do_reset();
    chk("t5_no_end", 128'(end_cnt[0]), 128'(0));
    raise(0, r128(), {$urandom(), $urandom()});
    raise(1, r128(), {$urandom(), $urandom()});
    run_until_ends(1, 3 * L);
    if (order.size() >= 1) chk("t5_tie", 128'(order[0]), 128'(0));
    run(3 * (L + 2));

    // Early start drop at cnt=2 still completes normally.
    clear_obs();
    p6 = r128(); k6 = {$urandom(), $urandom()};
    raise(0, p6, k6);
    run(1);
    gc = g_cyc;
    run(2);
    s[0] = 1'b0;
    run_until_ends(1, 3 * L);
    chk("t6_end_lat", 128'(end_cyc[0] - gc), 128'(L));
    chk("t6_res", req0_result, f(p6, k6));
    run(4);

    // Random traffic with occasional early drops.
    repeat (3000) begin
      tick();
      for (int i = 0; i < 2; i++)
        if (exp_end(i)) begin s[i] = 1'b0; outst[i] = 0; end
        else if (!outst[i] && $urandom_range(0, 2) == 0) raise(i, r128(), {$urandom(), $urandom()});
        else if (s[i] && inflight && owner == i && $urandom_range(0, 7) == 0) s[i] = 1'b0;
    end
    run(3 * (L + 2));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
